mult_ctrl: RTL and testbench
============================

# mult_ctrl

Sequencer for the processor's multiply path. It accepts a one-cycle `ctrl_MULT` request from the execute stage and latches both operands. It then drives the radix-4 Booth step unit through 16 iterations and truncates the 64-bit product to 32 bits. Finally it reports signed overflow and pulses `data_resultRDY` so the execute stage can release its stall.

## Interface
- `STEPS`, 16: radix-4 iterations per multiply (32-bit operands / 2 bits per step).
- `CNT_W`, 5: step counter width; must hold 0..STEPS.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ctrl_MULT`  in  1  start pulse; sampled on rising edge of `clock`.
- `data_operandA`  in  32  multiplicand, two's complement; sampled only when `ctrl_MULT`=1.
- `data_operandB`  in  32  multiplier, two's complement; sampled only when `ctrl_MULT`=1.
- `data_result`  out  32  low 32 bits of the signed product.
- `data_exception`  out  1  signed overflow of the 32-bit result.
- `data_resultRDY`  out  1  one-cycle completion pulse.

## Operation
- Reset values:
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0.
  - State IDLE, counter 0, operand registers 0.
- States: IDLE, BUSY, DONE.
- IDLE, `ctrl_MULT`=1:
  - Latch A and B.
  - Assert the step unit's load/first-step control for that edge.
  - Set counter to 1 and go to BUSY.
- BUSY:
  - Each edge advances the step unit one iteration and increments the counter.
  - When the counter reaches `STEPS`, capture the product into the output registers and go to DONE.
- DONE:
  - `data_resultRDY`=1 for exactly this one cycle.
  - Next edge goes to IDLE.
  - Outputs hold their values until the next capture.
- `ctrl_MULT`=1 in BUSY or DONE restarts the operation:
  - Latch the new operands and set counter to 1.
  - Go to or stay in BUSY.
  - The in-flight result is abandoned and no RDY pulse is issued for it.
  - A restart seen in DONE still lets that cycle's RDY pulse complete.
- Result: `data_result` = product[31:0].
- Overflow: `data_exception` = 1 iff product[63:31] is not all-zero and not all-one, i.e. the result does not fit in a signed 32-bit value.
- Product arithmetic is full 64-bit signed. The counter never wraps; it saturates at `STEPS` while in DONE.
- Operands are held in registers for the whole operation. Input changes while BUSY have no effect.
- Asynchronous `reset` mid-operation:
  - Return to IDLE and zero all outputs at once.
  - No RDY pulse for the aborted operation.
  - The first `ctrl_MULT` after deassertion starts cleanly.

## Timing
- Request sampled at edge E0; Booth iterations occur at edges E0..E15.
- Result, exception and RDY become visible after E16.
- `data_resultRDY` is high from E16 to E17, a latency of 16 cycles from the request edge.
- Back-to-back: a new `ctrl_MULT` is accepted in the DONE cycle. Its RDY follows 16 cycles later.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `mult_pkg`:
  - state enum {IDLE, BUSY, DONE}
  - `STEPS`, `CNT_W`
  - localparam `OVF_LSB`=31 (lowest product bit in the overflow check)
- One sub-module instance: the existing radix-4 step unit `booth`, instantiated unchanged.
  - Driven with the latched operands and the load control.
  - Its 64-bit `product` is read at capture.
- Overflow check and state machine are local logic.

## Test plan
- Basic: A=3, B=4 -> `data_result`=12, `data_exception`=0, `data_resultRDY` high exactly 16 cycles after the request edge, for 1 cycle.
- Signed operands:
  - A=-7, B=6 -> `data_result`=0xFFFFFFD6 (-42), no exception.
  - A=0x80000000, B=1 -> 0x80000000, no exception.
- Overflow:
  - A=0x7FFFFFFF, B=2 -> `data_result`=0xFFFFFFFE, `data_exception`=1.
  - A=0x80000000, B=-1 -> 0x80000000, exception=1.
  - A=B=0x00010000 -> 0, exception=1.
- Restart: start 5x5, assert `ctrl_MULT` with 9x9 at cycle 7 -> single RDY 16 cycles after the second request with result 81; no RDY for 25.
- Reset mid-op: assert `reset` at cycle 10 of 3x4 -> outputs 0 immediately, no RDY. A fresh 2x8 after deassertion -> 16 with normal latency.
- Back-to-back: issue 6x7 in the DONE cycle of 3x4 -> RDY with 12, then RDY with 42 exactly 16 cycles after the second request; outputs held between.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiply sequencer and its Booth step unit.
package mult_pkg;

  localparam int STEPS   = 16;
  localparam int CNT_W   = 5;
  localparam int OVF_LSB = 31;

  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The result fits a signed 32-bit value only when product[63:31] is a pure sign extension.
  function automatic logic ovf_check(input logic [63:0] product);
    logic [63-OVF_LSB:0] w_top;
    w_top = product[63:OVF_LSB];
    return !((w_top == '0) || (&w_top));
  endfunction

endpackage

// File: rtl/booth.sv
// Radix-4 Booth step unit: one iteration per enabled edge; i_load seeds the
// accumulator from i_a/i_b and performs the first iteration on the same edge.
module booth (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_product
);

  logic [33:0] r_m;
  logic [33:0] r_hi;
  logic [31:0] r_lo;
  logic        r_q1;

  logic [33:0] w_m;
  logic [33:0] w_hi_in;
  logic [31:0] w_lo_in;
  logic        w_q1_in;
  logic [33:0] w_pp;
  logic [33:0] w_sum;

  always_comb begin
    w_m     = i_load ? {{2{i_a[31]}}, i_a} : r_m;
    w_hi_in = i_load ? 34'd0 : r_hi;
    w_lo_in = i_load ? i_b : r_lo;
    w_q1_in = i_load ? 1'b0 : r_q1;
  end

  // Two extra accumulator bits keep +/-2M and the running sum in range.
  always_comb begin
    w_pp = 34'd0;
    case ({w_lo_in[1:0], w_q1_in})
      3'b001, 3'b010: w_pp = w_m;
      3'b011:         w_pp = w_m << 1;
      3'b100:         w_pp = -(w_m << 1);
      3'b101, 3'b110: w_pp = -w_m;
      default:        w_pp = 34'd0;
    endcase
    w_sum = w_hi_in + w_pp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m  <= 34'd0;
      r_hi <= 34'd0;
      r_lo <= 32'd0;
      r_q1 <= 1'b0;
    end else if (i_load || i_step) begin
      r_m  <= w_m;
      r_hi <= {{2{w_sum[33]}}, w_sum[33:2]};
      r_lo <= {w_sum[1:0], w_lo_in[31:2]};
      r_q1 <= w_lo_in[1];
    end
  end

  assign o_product = {r_hi[31:0], r_lo};

endmodule

// File: rtl/mult_ctrl.sv
// Multiply sequencer: latches operands on ctrl_MULT, runs 16 Booth iterations,
// then registers the truncated product, signed overflow and a one-cycle RDY pulse.
module mult_ctrl
  import mult_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic [1:0]  o_dbg_state
);

  // Handshake: ctrl_MULT is a one-cycle request sampled on the rising edge in any
  // state; data_resultRDY is a one-cycle completion pulse with no back-pressure.

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_result;
  logic             r_exc;
  logic             r_rdy;

  logic             w_load;
  logic             w_step;
  logic             w_capture;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [63:0]      w_product;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // A request in any state restarts; the in-flight product is simply dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = ctrl_MULT ? BUSY : IDLE;
      BUSY:    w_next = ctrl_MULT ? BUSY : ((r_cnt == STEPS_C) ? DONE : BUSY);
      DONE:    w_next = ctrl_MULT ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load    = ctrl_MULT;
    w_step    = 1'b0;
    w_capture = 1'b0;
    if (r_state == BUSY && !ctrl_MULT) begin
      w_step    = (r_cnt != STEPS_C);
      w_capture = (r_cnt == STEPS_C);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
    end else if (w_load) begin
      r_cnt <= CNT_W'(1);
      r_a   <= data_operandA;
      r_b   <= data_operandB;
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The step unit needs the operands on the load edge itself, before r_a/r_b update.
  assign w_a = w_load ? data_operandA : r_a;
  assign w_b = w_load ? data_operandB : r_b;

  booth u_booth (
    .clk       (clock),
    .rst       (reset),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_product (w_product)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= w_capture;
      if (w_capture) begin
        r_result <= w_product[31:0];
        r_exc    <= ovf_check(w_product);
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: latency, signed results, overflow, restart,
// asynchronous reset and back-to-back requests.
module tb_mult_ctrl;
  import mult_pkg::*;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [1:0]  o_dbg_state;

  int errors;
  int checks;
  int rdy_cnt;
  int rdy_base;
  logic [31:0] last_res;

  mult_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .o_dbg_state    (o_dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (data_resultRDY) rdy_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request across the next rising edge (E0), then scrambles the operands.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom();
    data_operandB = $urandom();
  endtask

  // Called just after E0; checks the pre-completion hold, the pulse at E16 and its end at E17.
  task automatic await_result(input logic [31:0] er, input logic ee, input string tag);
    repeat (15) @(posedge clock);
    @(negedge clock);
    check({tag, "_rdy_pre"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_hold_pre"}, data_result, last_res);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_rdy"}, {31'd0, data_resultRDY}, 32'd1);
    check({tag, "_result"}, data_result, er);
    check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
    check({tag, "_state_done"}, {30'd0, o_dbg_state}, {30'd0, 2'(DONE)});
    last_res = er;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ee, input string tag);
    @(negedge clock);
    rdy_base = rdy_cnt;
    issue(a, b);
    await_result(er, ee, tag);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_rdy_post"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_hold_post"}, data_result, er);
    check({tag, "_pulses"}, rdy_cnt - rdy_base, 32'd1);
  endtask

  initial begin
    errors = 0; checks = 0; rdy_cnt = 0; last_res = 32'd0;
    ctrl_MULT = 1'b0; data_operandA = 32'd0; data_operandB = 32'd0;
    reset = 1'b1;
    #3;
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_state", {30'd0, o_dbg_state}, {30'd0, 2'(IDLE)});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    run(32'd3, 32'd4, 32'd12, 1'b0, "basic");
    run(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0, "neg7x6");
    run(32'h80000000, 32'd1, 32'h80000000, 1'b0, "min_x1");
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, "m1xm1");
    run(32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, "ovf_max_x2");
    run(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "ovf_min_xm1");
    run(32'h00010000, 32'h00010000, 32'd0, 1'b1, "ovf_2p32");
    run(32'd0, 32'h12345678, 32'd0, 1'b0, "zero");

    // restart: 5x5 abandoned by 9x9 at cycle 7
    @(negedge clock);
    rdy_base = rdy_cnt;
    issue(32'd5, 32'd5);
    repeat (6) @(posedge clock);
    @(negedge clock);
    issue(32'd9, 32'd9);
    await_result(32'd81, 1'b0, "restart");
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("restart_pulses", rdy_cnt - rdy_base, 32'd1);

    // asynchronous reset at cycle 10 of 3x4
    @(negedge clock);
    rdy_base = rdy_cnt;
    issue(32'd3, 32'd4);
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst_result", data_result, 32'd0);
    check("arst_exc", {31'd0, data_exception}, 32'd0);
    check("arst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("arst_state", {30'd0, o_dbg_state}, {30'd0, 2'(IDLE)});
    @(negedge clock);
    reset = 1'b0;
    last_res = 32'd0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("arst_no_pulse", rdy_cnt - rdy_base, 32'd0);
    run(32'd2, 32'd8, 32'd16, 1'b0, "after_rst");

    // back-to-back: 6x7 accepted in the DONE cycle of 3x4
    @(negedge clock);
    rdy_base = rdy_cnt;
    issue(32'd3, 32'd4);
    await_result(32'd12, 1'b0, "b2b_first");
    issue(32'd6, 32'd7);
    @(negedge clock);
    check("b2b_rdy_drop", {31'd0, data_resultRDY}, 32'd0);
    check("b2b_state_busy", {30'd0, o_dbg_state}, {30'd0, 2'(BUSY)});
    check("b2b_hold", data_result, 32'd12);
    await_result(32'd42, 1'b0, "b2b_second");
    @(posedge clock);
    @(negedge clock);
    check("b2b_rdy_post", {31'd0, data_resultRDY}, 32'd0);
    check("b2b_pulses", rdy_cnt - rdy_base, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
